// File: rtl/uart_reg_bank.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_reg_bank
// Decodes assembled UART packets into per-channel HS/LS PWM register sets.
// Each channel keeps a shadow set, written by packets, and an active set that
// drives the PWM. A commit copies shadow to active only while the channel's
// PWM is idle. Adds a serial readback of one channel's active set and a
// saturating error counter.
//
// Optional feature macro: REG_BANK_CSUM_EN
//   defined   : byte11 must equal XOR(func_reg, b1..b10), else the packet is
//               dropped and counted as an error. Readback appends a 14th byte,
//               the XOR of readback bytes 1..13.
//   undefined : byte11 is ignored and readback is 13 bytes.
//
// Ports
//   clk_50M        in   system clock
//   rst_n          in   asynchronous active-low reset
//   func_reg       in   packet function code
//   rev_pkt        in   data bytes 1..11, byte1 = [87:80], byte11 = [7:0]
//   pack_done      in   1-cycle strobe, func_reg/rev_pkt valid this cycle
//   pwm_busy       in   per-channel PWM busy
//   hs_ctrl_sta    out  active HS control, ch i at [8i+7:8i]
//   duty_num       out  active duty
//   pulse_dessert  out  active dessert, ch i at [16i+15:16i]
//   pulse_num      out  active pulse count
//   pat            out  active pattern, ch i at [PAT_W*i +: PAT_W]
//   ls_ctrl_sta    out  active LS control
//   hs_pwm_ch      out  last accepted HS channel
//   ls_pwm_ch      out  last accepted LS channel
//   commit_pulse   out  1-cycle strobe when a channel's active set updates
//   pend_mask      out  commits waiting for an idle PWM
//   tx_data        out  readback byte
//   tx_valid       out  readback byte available
//   tx_ready       in   byte accepted on tx_valid & tx_ready
//   rb_busy        out  readback in progress
//   err_cnt        out  saturating error count
// -----------------------------------------------------------------------------
module uart_reg_bank #(
   parameter int NUM_CH = 4,
   parameter int PAT_W  = 32
) (
   input  logic                    clk_50M,
   input  logic                    rst_n,
   input  logic [7:0]              func_reg,
   input  logic [87:0]             rev_pkt,
   input  logic                    pack_done,
   input  logic [NUM_CH-1:0]       pwm_busy,
   output logic [8*NUM_CH-1:0]     hs_ctrl_sta,
   output logic [8*NUM_CH-1:0]     duty_num,
   output logic [16*NUM_CH-1:0]    pulse_dessert,
   output logic [8*NUM_CH-1:0]     pulse_num,
   output logic [PAT_W*NUM_CH-1:0] pat,
   output logic [8*NUM_CH-1:0]     ls_ctrl_sta,
   output logic [7:0]              hs_pwm_ch,
   output logic [7:0]              ls_pwm_ch,
   output logic [NUM_CH-1:0]       commit_pulse,
   output logic [NUM_CH-1:0]       pend_mask,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    rb_busy,
   output logic [7:0]              err_cnt
);

`ifdef REG_BANK_CSUM_EN
   localparam int RB_LEN = 14;
`else
   localparam int RB_LEN = 13;
`endif
   localparam logic [3:0] RB_LAST  = 4'(RB_LEN - 1);
   localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

   typedef enum logic [1:0] {RB_IDLE, RB_LOAD, RB_SEND} rb_state_t;

   rb_state_t         state_reg, state_next;
   logic [3:0]        idx_reg;
   logic [7:0]        rb_ch_reg;
   logic [7:0]        rb_buf [RB_LEN];
   logic              rb_load;

   logic [NUM_CH-1:0] pend_reg;
   logic [NUM_CH-1:0] commit_pulse_reg;
   logic [NUM_CH-1:0] commit_fire;
   logic [NUM_CH-1:0] set_bits;
   logic [7:0]        err_cnt_reg;
   logic [7:0]        hs_pwm_ch_reg;
   logic [7:0]        ls_pwm_ch_reg;

   logic              wr_hs, wr_ls, set_en, rb_start, err_clr, err_inc;
   logic              ch_ok, csum_ok;

   // ---------------- packet byte extraction ----------------
   logic [7:0]  pkt_byte [1:11];
   logic [31:0] pat_word;

   genvar gi;
   generate
      for (gi = 1; gi <= 11; gi++) begin : g_byte
         assign pkt_byte[gi] = rev_pkt[8*(11-gi) +: 8];
      end
   endgenerate

   assign pat_word = {pkt_byte[7], pkt_byte[8], pkt_byte[9], pkt_byte[10]};
   assign ch_ok    = (pkt_byte[1] < NUM_CH_B);

   // Upper pattern bits are dropped when PAT_W < 32.
   logic unused_pat;
   assign unused_pat = ^pat_word;

`ifdef REG_BANK_CSUM_EN
   logic [7:0] csum_calc;
   always_comb begin
      csum_calc = func_reg;
      for (int k = 1; k <= 10; k++) begin
         csum_calc = csum_calc ^ pkt_byte[k];
      end
   end
   assign csum_ok = (csum_calc == pkt_byte[11]);
`else
   logic unused_csum;
   assign unused_csum = ^pkt_byte[11];
   assign csum_ok     = 1'b1;
`endif

   // ---------------- packet decode ----------------
   // At most one action or one error per packet.
   always_comb begin
      wr_hs    = 1'b0;
      wr_ls    = 1'b0;
      set_en   = 1'b0;
      rb_start = 1'b0;
      err_clr  = 1'b0;
      err_inc  = 1'b0;
      if (pack_done) begin
         if (!csum_ok) begin
            err_inc = 1'b1;
         end else begin
            case (func_reg)
               8'h01: if (ch_ok) wr_hs = 1'b1; else err_inc = 1'b1;
               8'h02: if (ch_ok) wr_ls = 1'b1; else err_inc = 1'b1;
               8'h03: set_en = 1'b1;
               8'h04: if (ch_ok && state_reg == RB_IDLE) rb_start = 1'b1;
                      else err_inc = 1'b1;
               8'h05: err_clr = 1'b1;
               default: err_inc = 1'b1;
            endcase
         end
      end
   end

   assign set_bits = set_en ? pkt_byte[1][NUM_CH-1:0] : '0;

   // ---------------- per-channel shadow / active sets ----------------
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [7:0]       sh_hs_reg, sh_duty_reg, sh_num_reg, sh_ls_reg;
         logic [15:0]      sh_dess_reg;
         logic [PAT_W-1:0] sh_pat_reg;
         logic [7:0]       act_hs_reg, act_duty_reg, act_num_reg, act_ls_reg;
         logic [15:0]      act_dess_reg;
         logic [PAT_W-1:0] act_pat_reg;
         logic             sel;

         assign sel             = (pkt_byte[1] == 8'(gi));
         assign commit_fire[gi] = pend_reg[gi] & ~pwm_busy[gi];

         // Active copies the shadow as it stood before this edge, so a
         // same-cycle shadow write lands only in the next commit.
         always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
               sh_hs_reg    <= '0;
               sh_duty_reg  <= '0;
               sh_dess_reg  <= '0;
               sh_num_reg   <= '0;
               sh_pat_reg   <= '0;
               sh_ls_reg    <= '0;
               act_hs_reg   <= '0;
               act_duty_reg <= '0;
               act_dess_reg <= '0;
               act_num_reg  <= '0;
               act_pat_reg  <= '0;
               act_ls_reg   <= '0;
            end else begin
               if (wr_hs && sel) begin
                  sh_hs_reg   <= pkt_byte[2];
                  sh_duty_reg <= pkt_byte[3];
                  sh_dess_reg <= {pkt_byte[4], pkt_byte[5]};
                  sh_num_reg  <= pkt_byte[6];
                  sh_pat_reg  <= pat_word[PAT_W-1:0];
               end
               if (wr_ls && sel) begin
                  sh_ls_reg <= pkt_byte[2];
               end
               if (commit_fire[gi]) begin
                  act_hs_reg   <= sh_hs_reg;
                  act_duty_reg <= sh_duty_reg;
                  act_dess_reg <= sh_dess_reg;
                  act_num_reg  <= sh_num_reg;
                  act_pat_reg  <= sh_pat_reg;
                  act_ls_reg   <= sh_ls_reg;
               end
            end
         end

         assign hs_ctrl_sta[8*gi +: 8]       = act_hs_reg;
         assign duty_num[8*gi +: 8]          = act_duty_reg;
         assign pulse_dessert[16*gi +: 16]   = act_dess_reg;
         assign pulse_num[8*gi +: 8]         = act_num_reg;
         assign pat[PAT_W*gi +: PAT_W]       = act_pat_reg;
         assign ls_ctrl_sta[8*gi +: 8]       = act_ls_reg;
      end
   endgenerate

   // ---------------- shared control registers ----------------
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg         <= '0;
         commit_pulse_reg <= '0;
         err_cnt_reg      <= '0;
         hs_pwm_ch_reg    <= '0;
         ls_pwm_ch_reg    <= '0;
      end else begin
         // A new request wins over the clear of a commit firing this cycle.
         pend_reg         <= (pend_reg & ~commit_fire) | set_bits;
         commit_pulse_reg <= commit_fire;
         if (err_clr) begin
            err_cnt_reg <= '0;
         end else if (err_inc && err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
         end
         if (wr_hs) hs_pwm_ch_reg <= pkt_byte[1];
         if (wr_ls) ls_pwm_ch_reg <= pkt_byte[1];
      end
   end

   assign pend_mask    = pend_reg;
   assign commit_pulse = commit_pulse_reg;
   assign err_cnt      = err_cnt_reg;
   assign hs_pwm_ch    = hs_pwm_ch_reg;
   assign ls_pwm_ch    = ls_pwm_ch_reg;

   // ---------------- readback FSM ----------------
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RB_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      rb_load    = 1'b0;
      tx_valid   = 1'b0;
      rb_busy    = 1'b0;
      case (state_reg)
         RB_IDLE: begin
            if (rb_start) state_next = RB_LOAD;
         end
         RB_LOAD: begin
            rb_busy    = 1'b1;
            rb_load    = 1'b1;
            state_next = RB_SEND;
         end
         RB_SEND: begin
            rb_busy  = 1'b1;
            tx_valid = 1'b1;
            if (tx_ready && idx_reg == RB_LAST) state_next = RB_IDLE;
         end
         default: state_next = RB_IDLE;
      endcase
   end

   // Select the requested channel's active set for the snapshot.
   logic [7:0]  snap_hs, snap_duty, snap_num, snap_ls;
   logic [15:0] snap_dess;
   logic [31:0] snap_pat;

   always_comb begin
      snap_hs   = '0;
      snap_duty = '0;
      snap_dess = '0;
      snap_num  = '0;
      snap_pat  = '0;
      snap_ls   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rb_ch_reg == 8'(c)) begin
            snap_hs   = hs_ctrl_sta[8*c +: 8];
            snap_duty = duty_num[8*c +: 8];
            snap_dess = pulse_dessert[16*c +: 16];
            snap_num  = pulse_num[8*c +: 8];
            snap_pat  = 32'(pat[PAT_W*c +: PAT_W]);
            snap_ls   = ls_ctrl_sta[8*c +: 8];
         end
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         rb_ch_reg <= '0;
         idx_reg   <= '0;
         for (int k = 0; k < RB_LEN; k++) begin
            rb_buf[k] <= '0;
         end
      end else begin
         if (rb_start) rb_ch_reg <= pkt_byte[1];
         if (rb_load) begin
            idx_reg    <= '0;
            rb_buf[0]  <= 8'hA5;
            rb_buf[1]  <= 8'h84;
            rb_buf[2]  <= rb_ch_reg;
            rb_buf[3]  <= snap_hs;
            rb_buf[4]  <= snap_duty;
            rb_buf[5]  <= snap_dess[15:8];
            rb_buf[6]  <= snap_dess[7:0];
            rb_buf[7]  <= snap_num;
            rb_buf[8]  <= snap_pat[31:24];
            rb_buf[9]  <= snap_pat[23:16];
            rb_buf[10] <= snap_pat[15:8];
            rb_buf[11] <= snap_pat[7:0];
            rb_buf[12] <= snap_ls;
`ifdef REG_BANK_CSUM_EN
            rb_buf[13] <= 8'hA5 ^ 8'h84 ^ rb_ch_reg ^ snap_hs ^ snap_duty ^
                          snap_dess[15:8] ^ snap_dess[7:0] ^ snap_num ^
                          snap_pat[31:24] ^ snap_pat[23:16] ^ snap_pat[15:8] ^
                          snap_pat[7:0] ^ snap_ls;
`endif
         end else if (tx_valid && tx_ready) begin
            // Wrap on the last byte so the index never points past the buffer.
            idx_reg <= (idx_reg == RB_LAST) ? 4'd0 : idx_reg + 4'd1;
         end
      end
   end

   assign tx_data = rb_buf[idx_reg];

endmodule
